nios_fprint_sys_info: RTL and testbench
=======================================

Name: nios_fprint_sys_info

Overview:
Parametrised successor to the fixed system-ID slave: an Avalon-MM register file on the Nios fingerprinting system interconnect.
- Identification: system ID, build timestamp, version and core count.
- Run-time state: free-running 64-bit uptime counter with coherent high-word shadow, a scratch register, and per-core boot-ready flags.
- Reads have a fixed one-cycle latency with `readdatavalid`.
- Software on any core uses it for build checking, timing and boot rendezvous.

Parameters:
- SYS_ID, 32'h539F_2A76, value of register 0 (system ID).
- TIMESTAMP, 32'h0, value of register 1 (build timestamp, Unix seconds).
- VERSION, 8'h02, block version reported in CONFIG[15:8].
- NUM_CORES, 4, number of boot-ready flags; legal range 1..32.
- SCRATCH_RESET, 32'h0, reset value of SCRATCH.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  byte lanes for write
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse, readdata valid
- core_ready  out  NUM_CORES  boot-ready flags, bit i = core i

Behaviour:
- Reset (async assert, sync deassert handled upstream). All of the following are cleared asynchronously:
  - readdata=0, readdatavalid=0
  - uptime=0, uptime_hi_shadow=0
  - scratch=SCRATCH_RESET, core_ready=0
- Uptime: 64-bit counter, +1 every cycle out of reset; wraps from 2^64-1 to 0 with no flag.
- Register map. RO registers ignore writes.
  - 0 SYS_ID, RO.
  - 1 TIMESTAMP, RO.
  - 2 CONFIG, RO: [7:0]=NUM_CORES, [15:8]=VERSION, [31:16]=0.
  - 3 UPTIME_LO, RO: returns uptime[31:0] as sampled in the read-accept cycle. The same edge copies uptime[63:32] into the shadow.
  - 4 UPTIME_HI, RO: returns the shadow, not the live counter. The shadow changes only on UPTIME_LO reads.
  - 5 SCRATCH, RW: per-lane update; byte k written only when byteenable[k]=1.
  - 6 READY_SET, write-1-to-set core_ready[NUM_CORES-1:0]. Reads return core_ready zero-extended.
  - 7 READY_CLR, write-1-to-clear core_ready. Reads return core_ready zero-extended.
  - For registers 6 and 7, writedata bits at or above NUM_CORES are ignored and byteenable is ignored.
- Read timing:
  - read=1 at edge t → readdata and readdatavalid=1 at edge t+1.
  - readdatavalid is high for exactly one cycle per accepted read.
  - readdata holds its last value when no read is accepted.
  - Back-to-back reads every cycle are supported; no waitrequest.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value and the write takes effect at the same edge.
- read and write to different registers in one cycle: both are performed independently.
- core_ready is a direct register output; it changes on the edge after the write.
- reset_n asserted mid-read: the pending readdatavalid is cancelled; no pulse follows deassertion.
- Width rules: CONFIG[7:0] holds NUM_CORES truncated to 8 bits, which always fits since NUM_CORES≤32. Elaboration-time error if NUM_CORES is outside 1..32.

Decomposition:
- Shared package nios_fprint_sys_info_pkg holds:
  - address constants ADDR_SYS_ID=0 … ADDR_READY_CLR=7
  - CONFIG field offsets
  - the 3-bit address typedef
  - the 32-bit word typedef
- One natural sub-module, nios_fprint_uptime_ctr: the 64-bit counter plus hi-word shadow, with a sample-enable input. Decode, scratch, ready flags and the read mux stay in the top.

Test Plan:
1. Reset, then read addresses 0, 1, 2 → readdata 32'h539F2A76, 32'h0 and 32'h0000_0204, each with readdatavalid one cycle after read.
2. Stimulus and response for the uptime shadow:
   - Force uptime to 64'h0000_0001_FFFF_FFFE.
   - Read UPTIME_LO → 32'hFFFF_FFFE.
   - Wait 5 cycles, then read UPTIME_HI → 32'h1, not 32'h2 (the live high word has carried).
3. Write SCRATCH with 32'hAABBCCDD and byteenable=4'hF, then write 32'h11223344 with byteenable=4'b0101 → SCRATCH reads 32'hAA22CC44.
4. Write READY_SET=32'hFFFF_FFFF with NUM_CORES=4 → core_ready=4'hF and a read returns 32'hF. Then write READY_CLR=32'h5 → core_ready=4'hA.
5. Issue read and write to SCRATCH together in one cycle (old value 32'h0, new 32'h1234) → readdata 32'h0; the next read returns 32'h1234.
6. Assert reset_n during a read cycle → no readdatavalid pulse; core_ready=0 and SCRATCH=SCRATCH_RESET after reset.

Source files
------------

// File: rtl/nios_fprint_sys_info_pkg.sv
// Shared definitions for the Nios fingerprinting system-info register file.
// Provides:
//   - the word address typedef and the register address map
//   - the 32-bit data word typedef
//   - the CONFIG register field offsets
package nios_fprint_sys_info_pkg;

  typedef logic [2:0]  addr_t;
  typedef logic [31:0] word_t;

  localparam addr_t ADDR_SYS_ID    = 3'd0;
  localparam addr_t ADDR_TIMESTAMP = 3'd1;
  localparam addr_t ADDR_CONFIG    = 3'd2;
  localparam addr_t ADDR_UPTIME_LO = 3'd3;
  localparam addr_t ADDR_UPTIME_HI = 3'd4;
  localparam addr_t ADDR_SCRATCH   = 3'd5;
  localparam addr_t ADDR_READY_SET = 3'd6;
  localparam addr_t ADDR_READY_CLR = 3'd7;

  // CONFIG: [7:0] core count, [15:8] block version, [31:16] zero
  localparam int unsigned CFG_NUM_CORES_LSB = 0;
  localparam int unsigned CFG_VERSION_LSB   = 8;

endpackage

// File: rtl/nios_fprint_sys_info_if.sv
// Avalon-MM slave bus for the system-info register file.
// Signals:
//   address       word address
//   read, write   access strobes (no waitrequest)
//   writedata     write data
//   byteenable    write byte lanes
//   readdata      registered read data
//   readdatavalid one-cycle pulse per accepted read
// Modports: master (interconnect side), slave (register file side).
interface nios_fprint_sys_info_if;
  import nios_fprint_sys_info_pkg::*;

  addr_t       address;
  logic        read;
  logic        write;
  word_t       writedata;
  logic [3:0]  byteenable;
  word_t       readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/nios_fprint_uptime_ctr.sv
// Free-running 64-bit uptime counter with a coherent high-word shadow.
// Ports:
//   clock, reset_n    clock and asynchronous active-low reset
//   sample            copy the live high word into the shadow at this edge
//   uptime_lo         live counter bits [31:0]
//   uptime_hi_shadow  high word captured on the last sample
// The counter wraps silently from all-ones to zero.
module nios_fprint_uptime_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sample,
  output logic [31:0] uptime_lo,
  output logic [31:0] uptime_hi_shadow
);

  logic [63:0] count_q;
  logic [63:0] count_inc;
  logic [31:0] shadow_q;

  assign count_inc = count_q + 64'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q <= count_inc;
      // Pre-increment value so the shadow matches the low word returned in the same read
      if (sample) shadow_q <= count_q[63:32];
    end
  end

  assign uptime_lo        = count_q[31:0];
  assign uptime_hi_shadow = shadow_q;

endmodule

// File: rtl/nios_fprint_sys_info.sv
// System-info Avalon-MM register file: identification, uptime, scratch and
// per-core boot-ready flags.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   bus             Avalon-MM slave (one-cycle read latency, no waitrequest)
//   core_ready      boot-ready flags, bit i = core i
// Map: 0 SYS_ID, 1 TIMESTAMP, 2 CONFIG, 3 UPTIME_LO, 4 UPTIME_HI (shadow),
//      5 SCRATCH (byte-lane RW), 6 READY_SET (W1S), 7 READY_CLR (W1C).
module nios_fprint_sys_info
  import nios_fprint_sys_info_pkg::*;
#(
  parameter word_t       SYS_ID        = 32'h539F_2A76,
  parameter word_t       TIMESTAMP     = 32'h0,
  parameter logic [7:0]  VERSION       = 8'h02,
  parameter int unsigned NUM_CORES     = 4,
  parameter word_t       SCRATCH_RESET = 32'h0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  nios_fprint_sys_info_if.slave bus,
  output logic [NUM_CORES-1:0] core_ready
);

  if (NUM_CORES < 1 || NUM_CORES > 32) begin : g_num_cores_check
    $error("nios_fprint_sys_info: NUM_CORES must be in 1..32");
  end

  localparam logic [7:0] NumCores8  = NUM_CORES[7:0];
  localparam word_t      ConfigWord = (word_t'(VERSION)   << CFG_VERSION_LSB) |
                                      (word_t'(NumCores8) << CFG_NUM_CORES_LSB);

  word_t                 readdata_q;
  logic                  readdatavalid_q;
  word_t                 rdata_d;
  word_t                 scratch_q;
  word_t                 scratch_d;
  logic [NUM_CORES-1:0]  ready_q;
  logic [NUM_CORES-1:0]  ready_d;
  word_t                 ready_ext;
  logic                  uptime_sample;
  word_t                 uptime_lo;
  word_t                 uptime_hi_shadow;

  assign uptime_sample = bus.read && (bus.address == ADDR_UPTIME_LO);

  nios_fprint_uptime_ctr u_uptime (
    .clock            (clock),
    .reset_n          (reset_n),
    .sample           (uptime_sample),
    .uptime_lo        (uptime_lo),
    .uptime_hi_shadow (uptime_hi_shadow)
  );

  assign ready_ext = word_t'(ready_q);

  // Read mux sees pre-write state, so a same-cycle read/write returns the old value
  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      ADDR_SYS_ID:    rdata_d = SYS_ID;
      ADDR_TIMESTAMP: rdata_d = TIMESTAMP;
      ADDR_CONFIG:    rdata_d = ConfigWord;
      ADDR_UPTIME_LO: rdata_d = uptime_lo;
      ADDR_UPTIME_HI: rdata_d = uptime_hi_shadow;
      ADDR_SCRATCH:   rdata_d = scratch_q;
      ADDR_READY_SET: rdata_d = ready_ext;
      ADDR_READY_CLR: rdata_d = ready_ext;
      default:        rdata_d = '0;
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    ready_d   = ready_q;
    if (bus.write) begin
      case (bus.address)
        ADDR_SCRATCH: begin
          for (int k = 0; k < 4; k++) begin
            if (bus.byteenable[k]) scratch_d[8*k +: 8] = bus.writedata[8*k +: 8];
          end
        end
        // Byte lanes and bits above NUM_CORES are ignored for the flag registers
        ADDR_READY_SET: ready_d = ready_q | bus.writedata[NUM_CORES-1:0];
        ADDR_READY_CLR: ready_d = ready_q & ~bus.writedata[NUM_CORES-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      scratch_q       <= SCRATCH_RESET;
      ready_q         <= '0;
    end else begin
      readdatavalid_q <= bus.read;
      if (bus.read) readdata_q <= rdata_d;
      scratch_q <= scratch_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;
  assign core_ready        = ready_q;

endmodule

// File: tb/tb_nios_fprint_sys_info.sv
// Scoreboard bench for nios_fprint_sys_info: a behavioural register model
// predicts every read response into a queue; an independent monitor checks
// readdatavalid timing, read data, held readdata and core_ready.
module tb_nios_fprint_sys_info;
  import nios_fprint_sys_info_pkg::*;

  localparam int unsigned NC      = 4;
  localparam word_t       SYSID   = 32'h539F_2A76;
  localparam word_t       TS      = 32'h0;
  localparam logic [7:0]  VER     = 8'h02;
  localparam word_t       SCR_RST = 32'h0;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [NC-1:0] core_ready;

  nios_fprint_sys_info_if bus ();

  nios_fprint_sys_info #(
    .SYS_ID        (SYSID),
    .TIMESTAMP     (TS),
    .VERSION       (VER),
    .NUM_CORES     (NC),
    .SCRATCH_RESET (SCR_RST)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .core_ready (core_ready)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  word_t           exp_q[$];
  bit              exp_valid = 1'b0;
  word_t           m_last    = 32'h0;
  longint unsigned m_up      = 0;
  word_t           m_shadow  = 32'h0;
  word_t           m_scratch = SCR_RST;
  bit [31:0]       m_ready   = 32'h0;
  bit              force_now = 1'b0;
  longint unsigned force_val = 0;

  function automatic word_t model_read(input int unsigned a);
    case (a)
      0: return SYSID;
      1: return TS;
      2: return word_t'(NC) + (word_t'(VER) * 32'd256);
      3: return word_t'(m_up % 64'h1_0000_0000);
      4: return m_shadow;
      5: return m_scratch;
      default: return m_ready;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_up      = 0;
      m_shadow  = 32'h0;
      m_scratch = SCR_RST;
      m_ready   = 32'h0;
      m_last    = 32'h0;
      exp_valid = 1'b0;
      exp_q.delete();
    end else begin
      exp_valid = bus.read;
      if (bus.read) begin
        exp_q.push_back(model_read(int'(bus.address)));
        if (bus.address == 3'd3) m_shadow = word_t'(m_up / 64'h1_0000_0000);
      end
      if (bus.write) begin
        case (int'(bus.address))
          5: begin
            for (int k = 0; k < 4; k++) begin
              if (bus.byteenable[k]) m_scratch[8*k +: 8] = bus.writedata[8*k +: 8];
            end
          end
          6: m_ready = (m_ready | bus.writedata) & ((32'd1 << NC) - 32'd1);
          7: m_ready = m_ready & ~bus.writedata;
          default: ;
        endcase
      end
      m_up      = force_now ? force_val : m_up + 1;
      force_now = 1'b0;
    end
  end

  // Monitor
  always @(negedge clock) begin
    word_t w;
    n_cmp++;
    if (bus.readdatavalid !== exp_valid) begin
      n_bad++;
      $display("FAIL rdvalid: got %b want %b at %0t", bus.readdatavalid, exp_valid, $time);
    end
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        w      = exp_q.pop_front();
        m_last = w;
      end
    end
    n_cmp++;
    if (bus.readdata !== m_last) begin
      n_bad++;
      $display("FAIL readdata: got %h want %h at %0t", bus.readdata, m_last, $time);
    end
    n_cmp++;
    if (core_ready !== m_ready[NC-1:0]) begin
      n_bad++;
      $display("FAIL core_ready: got %h want %h at %0t", core_ready, m_ready[NC-1:0], $time);
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit rd, input bit wr, input int unsigned a, input word_t wd,
                     input logic [3:0] be);
    @(negedge clock);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = 3'(a);
    bus.writedata  = wd;
    bus.byteenable = be;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    bus.byteenable = 4'h0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_core_ready", word_t'(core_ready), 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;

    // Identification registers
    cyc(1, 0, 0, 32'h0, 4'h0);
    cyc(1, 0, 1, 32'h0, 4'h0);
    cyc(1, 0, 2, 32'h0, 4'h0);
    idle(2);

    // Uptime shadow across a carry into the high word
    @(negedge clock);
    force_val = 64'h0000_0001_FFFF_FFFE;
    force_now = 1'b1;
    force dut.u_uptime.count_inc = 64'h0000_0001_FFFF_FFFE;
    @(negedge clock);
    release dut.u_uptime.count_inc;
    bus.read    = 1'b1;
    bus.address = 3'd3;
    idle(5);
    cyc(1, 0, 4, 32'h0, 4'h0);
    idle(1);

    // Scratch byte lanes
    cyc(0, 1, 5, 32'hAABB_CCDD, 4'hF);
    cyc(0, 1, 5, 32'h1122_3344, 4'b0101);
    cyc(1, 0, 5, 32'h0, 4'h0);
    idle(1);

    // Ready flags
    cyc(0, 1, 6, 32'hFFFF_FFFF, 4'h0);
    cyc(1, 0, 6, 32'h0, 4'h0);
    check("ready_set", word_t'(core_ready), 32'hF);
    cyc(0, 1, 7, 32'h5, 4'h0);
    cyc(1, 0, 7, 32'h0, 4'h0);
    check("ready_clr", word_t'(core_ready), 32'hA);

    // Same-cycle read and write of scratch
    cyc(0, 1, 5, 32'h0, 4'hF);
    cyc(1, 1, 5, 32'h1234, 4'hF);
    cyc(1, 0, 5, 32'h0, 4'h0);
    idle(1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom,
          4'($urandom));
    end
    idle(1);
    cyc(0, 1, 6, 32'h3, 4'h0);
    cyc(0, 1, 5, 32'hDEAD_BEEF, 4'hF);

    // Reset during an accepted read: its valid pulse must never appear
    cyc(1, 0, 5, 32'h0, 4'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    bus.read = 1'b0;
    @(negedge clock);
    check("rst_rdvalid", word_t'(bus.readdatavalid), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    check("rst_core_ready", word_t'(core_ready), 32'h0);
    cyc(1, 0, 5, 32'h0, 4'h0);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
